// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b pipeline type definitions
package lc3b_types;
  typedef enum logic [1:0] {RUN, IND, HOLD} lc3b_pipe_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at all-ones; clear wins over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush control for the five-stage pipeline, with
// indirect (two-access) data sequencing and a saturating stall counter
module pipeline_ctrl
  import lc3b_types::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   imem_resp,
  input  logic                   dmem_req,
  input  logic                   dmem_indirect,
  input  logic                   dmem_resp,
  input  logic                   load_use,
  input  logic                   br_taken,
  input  logic                   perf_clear,
  output logic                   load_pc,
  output logic                   load_ifid,
  output logic                   load_idex,
  output logic                   load_exmem,
  output logic                   load_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   flush_exmem,
  output logic                   dmem_go,
  output logic                   dmem_phase,
  output logic [STALL_CNT_W-1:0] stall_count
);
  lc3b_pipe_state_t state, state_next;
  logic if_busy, mem_busy, advance, run;
  always_ff @(posedge clk) state <= !reset ? RUN : state_next;
  always_comb begin
    if_busy = !imem_resp;
    mem_busy = (state == RUN && dmem_req && !(dmem_resp && !dmem_indirect)) ||
               (state == IND && !dmem_resp);
    advance = !if_busy && !mem_busy;
    run = reset && advance;
    state_next = state == RUN ? (dmem_req && dmem_resp ? (dmem_indirect ? IND : if_busy ? HOLD : RUN) : RUN)
               : state == IND ? (dmem_resp ? (if_busy ? HOLD : RUN) : IND)
               : (if_busy ? HOLD : RUN);
    // a load-use hazard holds PC and IF/ID and bubbles ID/EX, unless a taken branch flushes it anyway
    load_pc = run && (br_taken || !load_use);
    load_ifid = run && (br_taken || !load_use);
    load_idex = run;
    load_exmem = run;
    load_memwb = run;
    flush_ifid = run && br_taken;
    flush_idex = run && (br_taken || load_use);
    flush_exmem = run && br_taken;
    dmem_go = reset && dmem_req && state != HOLD;
    dmem_phase = reset && state == IND;
  end
  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk  (clk),
    .clear(perf_clear || !reset),
    .inc  (!advance),
    .count(stall_count)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table vectors, directed sequences and random stimulus
// checked against an access-counting reference model
module tb_pipeline_ctrl;
  localparam int W = 4;
  localparam int SAT = (1 << W) - 1;
  localparam logic [7:0] RST = 8'b0000_0000;
  localparam logic [7:0] IDLE = 8'b1100_0000;
  typedef struct {
    logic [7:0] in;
    logic [9:0] out;
    int         cnt;
  } vec_t;
  logic clk = 1'b0;
  logic reset, imem_resp, dmem_req, dmem_indirect, dmem_resp, load_use, br_taken, perf_clear;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic flush_ifid, flush_idex, flush_exmem, dmem_go, dmem_phase;
  logic [W-1:0] stall_count;
  logic [9:0] outs, last_out;
  int last_cnt;
  int tests = 0, fails = 0;
  int m_second = 0, m_hold = 0, m_count = 0;
  vec_t tbl[10];

  always #5 clk = ~clk;

  pipeline_ctrl #(.STALL_CNT_W(W)) dut (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_indirect(dmem_indirect), .dmem_resp(dmem_resp), .load_use(load_use),
    .br_taken(br_taken), .perf_clear(perf_clear), .load_pc(load_pc),
    .load_ifid(load_ifid), .load_idex(load_idex), .load_exmem(load_exmem),
    .load_memwb(load_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .dmem_go(dmem_go), .dmem_phase(dmem_phase),
    .stall_count(stall_count)
  );

  assign outs = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                 flush_ifid, flush_idex, flush_exmem, dmem_go, dmem_phase};

  // model: how many data accesses the MEM-stage instruction still needs this cycle
  function automatic int left_before();
    if (m_hold != 0) return 0;
    if (m_second != 0) return 1;
    return dmem_req ? (dmem_indirect ? 2 : 1) : 0;
  endfunction

  function automatic bit m_adv();
    int lb;
    lb = left_before();
    return imem_resp && (lb - int'(dmem_resp && lb > 0)) == 0;
  endfunction

  function automatic logic [9:0] m_out();
    logic [1:0] mem;
    mem = {dmem_req && m_hold == 0, m_second != 0};
    if (!reset) return '0;
    if (!m_adv()) return {8'b0, mem};
    if (br_taken) return {8'b11111111, mem};
    if (load_use) return {8'b00111010, mem};
    return {8'b11111000, mem};
  endfunction

  task automatic tick();
    int lb, la;
    bit g, adv;
    @(posedge clk);
    lb = left_before();
    g = dmem_resp && lb > 0;
    la = lb - int'(g);
    adv = imem_resp && la == 0;
    if (!reset) begin
      m_second = 0;
      m_hold = 0;
      m_count = 0;
    end else begin
      m_count = perf_clear ? 0 : (!adv && m_count < SAT) ? m_count + 1 : m_count;
      m_hold = int'(!imem_resp && (m_hold != 0 || (g && la == 0)));
      m_second = int'(m_second != 0 ? la != 0 : (lb == 2 && g));
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [7:0] v, input string name);
    #1 {reset, imem_resp, dmem_req, dmem_indirect, dmem_resp, load_use, br_taken, perf_clear} = v;
    @(negedge clk);
    last_out = outs;
    last_cnt = int'(stall_count);
    check({name, "_out"}, int'(outs), int'(m_out()));
    check({name, "_cnt"}, last_cnt, m_count);
    tick();
  endtask

  initial begin
    // inputs: reset imem req ind resp lu br clr; outputs: 5 loads, 3 flushes, go, phase
    tbl[0] = '{8'b1100_0000, 10'b11111_000_00, 0};
    tbl[1] = '{8'b1100_0110, 10'b11111_111_00, 0};
    tbl[2] = '{8'b1100_0100, 10'b00111_010_00, 0};
    tbl[3] = '{8'b1110_1000, 10'b11111_000_10, 0};
    tbl[4] = '{8'b1000_0000, 10'b00000_000_00, 0};
    tbl[5] = '{8'b1110_0010, 10'b00000_000_10, 1};
    tbl[6] = '{8'b1110_1010, 10'b11111_111_10, 2};
    tbl[7] = '{8'b1100_0001, 10'b11111_000_00, 2};
    tbl[8] = '{8'b0111_1110, 10'b00000_000_00, 0};
    tbl[9] = '{8'b1100_0000, 10'b11111_000_00, 0};
    cycle(RST, "rst");
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].in, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_vec", i), int'(last_out), int'(tbl[i].out));
      check($sformatf("tbl%0d_vcnt", i), last_cnt, tbl[i].cnt);
    end
    cycle(RST, "rst");
    for (int i = 0; i < 10; i++) begin
      cycle(IDLE, "idle");
      check("idle_loads", int'(last_out), int'(10'b11111_000_00));
    end
    #1 check("idle_cnt", int'(stall_count), 0);
    cycle(RST, "rst");
    for (int i = 0; i < 3; i++) begin
      cycle(8'b1110_0000, "ldr_wait");
      check("ldr_frozen", int'(last_out), int'(10'b00000_000_10));
    end
    cycle(8'b1110_1000, "ldr_go");
    check("ldr_adv", int'(last_out), int'(10'b11111_000_10));
    #1 check("ldr_cnt", int'(stall_count), 3);
    cycle(IDLE, "ldr_after");
    check("ldr_run", int'(last_out), int'(10'b11111_000_00));
    cycle(RST, "rst");
    for (int c = 0; c < 6; c++) begin
      cycle((c == 2 || c == 5) ? 8'b1111_1000 : 8'b1111_0000, "ldi");
      check($sformatf("ldi_phase%0d", c), int'(last_out[0]), int'(c >= 3));
      check($sformatf("ldi_adv%0d", c), int'(last_out[9]), int'(c == 5));
    end
    #1 check("ldi_cnt", int'(stall_count), 5);
    cycle(RST, "rst");
    cycle(8'b1010_1000, "hold_done");
    check("hold_done_go", int'(last_out), int'(10'b00000_000_10));
    for (int i = 0; i < 3; i++) begin
      cycle(8'b1010_1000, "hold_wait");
      check("hold_no_go", int'(last_out), 0);
    end
    cycle(8'b1110_0000, "hold_adv");
    check("hold_adv_vec", int'(last_out), int'(10'b11111_000_00));
    #1 check("hold_cnt", int'(stall_count), 4);
    cycle(RST, "rst");
    for (int i = 0; i < 20; i++) cycle(8'b1000_0000, "sat");
    #1 check("sat_cnt", int'(stall_count), SAT);
    cycle(8'b1000_0001, "clr");
    #1 check("clr_cnt", int'(stall_count), 0);
    cycle(8'b1111_1000, "ind_enter");
    cycle(8'b0111_1111, "rst_in_ind");
    check("rst_outs", int'(last_out), 0);
    cycle(IDLE, "post_rst");
    check("post_rst_run", int'(last_out), int'(10'b11111_000_00));
    for (int i = 0; i < 600; i++) begin
      logic [7:0] v;
      v = {$urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0};
      cycle(v, $sformatf("rnd%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
